// File: rtl/axis_cpu_defs.sv
// Shared command/status definitions for axis_cpu and its loader.
// Pure declarations: no logic, no latency.
// Field layouts are fixed; all widths are visible here.
package axis_cpu_defs;

  localparam int CMD_W  = 32;
  localparam int ID_W   = 12;
  localparam int OP_W   = 4;
  localparam int DATA_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_ADDR  = 4'd1,
    OP_WR_HI = 4'd2,
    OP_WR_LO = 4'd3,  // commit; CPU post-increments its write address
    OP_RUN   = 4'd4,
    OP_ACK   = 4'd8   // CPU to loader, data = committed address
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK       = 3'd0,
    ERR_TIMEOUT  = 3'd1,
    ERR_MISMATCH = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_EMPTY    = 3'd4
  } err_e;

  // Command word: [31:20] id, [19:16] op, [15:0] data
  typedef struct packed {
    logic [ID_W-1:0]   id;
    op_e               op;
    logic [DATA_W-1:0] data;
  } cmd_word_t;

  // Status flit: [31:29] error, [28:16] reserved, [15:0] committed count
  typedef struct packed {
    err_e        err;
    logic [12:0] rsvd;
    logic [15:0] cnt;
  } status_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_FETCH,
    ST_HI,
    ST_LO,
    ST_WAIT_ACK,
    ST_RUN,
    ST_DRAIN,
    ST_STAT
  } ldr_state_e;

  function automatic status_t pack_status(input err_e err, input logic [15:0] cnt);
    status_t s;
    s.err  = err;
    s.rsvd = '0;
    s.cnt  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/axis_cpu_cmd_fmt.sv
// Packs target id, op code and data into one 32-bit command word.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module axis_cpu_cmd_fmt
  import axis_cpu_defs::*;
#(
  parameter int CPU_ID_WIDTH = 12
) (
  input  logic [CPU_ID_WIDTH-1:0] id_i,
  input  op_e                     op_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [CMD_W-1:0]        word_o
);

  cmd_word_t word_c;

  // Zero-extend the id into the fixed-width field and assemble the word
  always_comb begin
    word_c      = '0;
    word_c.id   = ID_W'(id_i);
    word_c.op   = op_i;
    word_c.data = data_i;
    word_o      = word_c;
  end

endmodule

// File: rtl/axis_cpu_loader.sv
// Serialises an AXI-Stream program packet into axis_cpu command words, checks acks, emits one status flit.
// Latency: flit accept -> WR_HI next cycle -> WR_LO the cycle after; then waits for the CPU ack.
// Backpressure: prog_TREADY drops while a command/ack is in flight; status holds until stat_TREADY.
module axis_cpu_loader
  import axis_cpu_defs::*;
#(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int CPU_ID_WIDTH    = 12,
  parameter int TARGET_ID       = 0,
  parameter int ACK_TIMEOUT     = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] prog_TDATA,
  input  logic        prog_TVALID,
  output logic        prog_TREADY,
  input  logic        prog_TLAST,
  output logic [31:0] cmd_TDATA,
  output logic        cmd_TVALID,
  input  logic [31:0] resp_TDATA,
  input  logic        resp_TVALID,
  output logic [31:0] stat_TDATA,
  output logic        stat_TVALID,
  input  logic        stat_TREADY,
  output logic        stat_TLAST,
  output logic        busy
);

  localparam int AW = CODE_ADDR_WIDTH;
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]             ADDR_MAX   = {1'b0, {AW{1'b1}}};
  localparam logic [TW-1:0]           TIMER_INIT = TW'(ACK_TIMEOUT);
  localparam logic [ID_W-1:0]         RESP_ID    = ID_W'(TARGET_ID);
  localparam logic [CPU_ID_WIDTH-1:0] CPU_ID     = CPU_ID_WIDTH'(TARGET_ID);

  ldr_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [15:0]       instr_lo_q, instr_lo_d;
  logic              last_q, last_d;
  err_e              err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              rdy_q, rdy_d;
  logic              cmd_vld_q, cmd_vld_d;
  logic [CMD_W-1:0]  cmd_dat_q, cmd_dat_d;

  logic [15:0]       instr_hi_c;
  op_e               cmd_op_c;
  logic [15:0]       cmd_data_c;
  logic [CMD_W-1:0]  cmd_word_c;
  logic [AW:0]       slot_c;
  cmd_word_t         resp_w;
  logic              prog_acc_c;
  logic              resp_hit_c;
  logic              resp_data_ok_c;

  // Next write slot, one bit wider than the code address so wrap is visible
  assign slot_c         = {1'b0, addr_q} + cnt_q;
  assign prog_acc_c     = prog_TVALID && rdy_q;
  assign resp_w         = resp_TDATA;
  assign resp_hit_c     = resp_TVALID && (resp_w.id == RESP_ID) && (resp_w.op == OP_ACK);
  assign resp_data_ok_c = (resp_w.data == 16'(slot_c));

  // State and datapath registers; reset abandons any packet in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      instr_lo_q <= '0;
      last_q     <= 1'b0;
      err_q      <= ERR_OK;
      timer_q    <= '0;
      rdy_q      <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      instr_lo_q <= instr_lo_d;
      last_q     <= last_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      rdy_q      <= rdy_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_dat_q  <= cmd_dat_d;
    end
  end

  // Packet FSM: next state, counters, error capture
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    instr_lo_d = instr_lo_q;
    last_d     = last_q;
    err_d      = err_q;
    timer_d    = timer_q;
    instr_hi_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (prog_acc_c) begin
          addr_d = prog_TDATA[AW-1:0];
          cnt_d  = '0;
          err_d  = ERR_OK;
          if (prog_TLAST) begin
            err_d   = ERR_EMPTY;
            state_d = ST_STAT;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: state_d = ST_FETCH;
      ST_FETCH: begin
        if (prog_acc_c) begin
          instr_lo_d = prog_TDATA[15:0];
          instr_hi_c = prog_TDATA[31:16];
          last_d     = prog_TLAST;
          if (slot_c > ADDR_MAX) begin
            err_d   = ERR_OVERFLOW;
            state_d = prog_TLAST ? ST_STAT : ST_DRAIN;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: state_d = ST_LO;
      ST_LO: begin
        timer_d = TIMER_INIT;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q - 1'b1;
        // A qualifying resp takes priority over a simultaneous timer expiry
        if (resp_hit_c) begin
          if (resp_data_ok_c) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = last_q ? ST_RUN : ST_FETCH;
          end else begin
            err_d   = ERR_MISMATCH;
            state_d = last_q ? ST_STAT : ST_DRAIN;
          end
        end else if (timer_q <= TW'(1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = last_q ? ST_STAT : ST_DRAIN;
        end
      end
      ST_RUN: state_d = ST_STAT;
      ST_DRAIN: begin
        if (prog_acc_c && prog_TLAST) state_d = ST_STAT;
      end
      ST_STAT: begin
        if (stat_TREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command and ready for the state being entered, so both are registered outputs
  always_comb begin
    cmd_vld_d  = 1'b0;
    cmd_op_c   = OP_NONE;
    cmd_data_c = '0;
    rdy_d      = (state_d == ST_IDLE) || (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    case (state_d)
      ST_ADDR: begin
        cmd_vld_d  = 1'b1;
        cmd_op_c   = OP_ADDR;
        cmd_data_c = 16'(addr_d);
      end
      ST_HI: begin
        cmd_vld_d  = 1'b1;
        cmd_op_c   = OP_WR_HI;
        cmd_data_c = instr_hi_c;
      end
      ST_LO: begin
        cmd_vld_d  = 1'b1;
        cmd_op_c   = OP_WR_LO;
        cmd_data_c = instr_lo_q;
      end
      ST_RUN: begin
        cmd_vld_d  = 1'b1;
        cmd_op_c   = OP_RUN;
      end
      default: ;
    endcase
  end

  axis_cpu_cmd_fmt #(
    .CPU_ID_WIDTH(CPU_ID_WIDTH)
  ) u_cmd_fmt (
    .id_i  (CPU_ID),
    .op_i  (cmd_op_c),
    .data_i(cmd_data_c),
    .word_o(cmd_word_c)
  );

  assign cmd_dat_d   = cmd_vld_d ? cmd_word_c : '0;

  assign prog_TREADY = rdy_q;
  assign cmd_TVALID  = cmd_vld_q;
  assign cmd_TDATA   = cmd_dat_q;
  assign stat_TVALID = (state_q == ST_STAT);
  assign stat_TLAST  = stat_TVALID;
  assign stat_TDATA  = stat_TVALID ? pack_status(err_q, 16'(cnt_q)) : '0;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_cpu_loader.sv
// Directed bench for axis_cpu_loader with a small CPU responder.
// Inputs driven and outputs sampled on the falling edge.
// Status handshake controlled by the bench, including stalls.
module tb_axis_cpu_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] prog_TDATA = '0;
  logic        prog_TVALID = 1'b0;
  logic        prog_TREADY;
  logic        prog_TLAST = 1'b0;
  logic [31:0] cmd_TDATA;
  logic        cmd_TVALID;
  logic [31:0] resp_TDATA = '0;
  logic        resp_TVALID = 1'b0;
  logic [31:0] stat_TDATA;
  logic        stat_TVALID;
  logic        stat_TREADY = 1'b0;
  logic        stat_TLAST;
  logic        busy;

  always #5 clk = ~clk;

  axis_cpu_loader dut (
    .clk        (clk),
    .rst        (rst),
    .prog_TDATA (prog_TDATA),
    .prog_TVALID(prog_TVALID),
    .prog_TREADY(prog_TREADY),
    .prog_TLAST (prog_TLAST),
    .cmd_TDATA  (cmd_TDATA),
    .cmd_TVALID (cmd_TVALID),
    .resp_TDATA (resp_TDATA),
    .resp_TVALID(resp_TVALID),
    .stat_TDATA (stat_TDATA),
    .stat_TVALID(stat_TVALID),
    .stat_TREADY(stat_TREADY),
    .stat_TLAST (stat_TLAST),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Ack modes: 0 correct ack, 1 never ack, 2 ack with wrong address, 3 decoy id then correct ack
  int          ack_mode = 0;
  int          ack_pend = 0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] ack_data = '0;
  logic [31:0] got[$];
  int          idle_nz = 0;

  typedef struct packed {
    logic [2:0][31:0] flit;
    int               nflit;
    int               ack;
    int               ncmd;
    logic [5:0][31:0] cmd;
    logic [31:0]      stat;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", nm, act, exp);
    end
  endtask

  // Command monitor plus CPU model: tracks write address, acks each WR_LO
  always @(negedge clk) begin
    resp_TVALID = 1'b0;
    resp_TDATA  = '0;
    if (!rst) ack_pend = 0;
    if (ack_pend > 0) begin
      ack_pend--;
      if (ack_pend == 1 && ack_mode == 3) begin
        resp_TVALID = 1'b1;
        resp_TDATA  = {12'h001, 4'h8, 16'hFFFF};
      end
      if (ack_pend == 0) begin
        resp_TVALID = 1'b1;
        resp_TDATA  = {12'h000, 4'h8, ack_data};
      end
    end
    if (cmd_TVALID) begin
      got.push_back(cmd_TDATA);
      if (cmd_TDATA[19:16] == 4'h1) cpu_addr = cmd_TDATA[15:0];
      if (cmd_TDATA[19:16] == 4'h3) begin
        if (ack_mode != 1) begin
          ack_pend = 3;
          ack_data = (ack_mode == 2) ? cpu_addr + 16'd1 : cpu_addr;
        end
        cpu_addr = cpu_addr + 16'd1;
      end
    end else if (cmd_TDATA != 32'h0) begin
      idle_nz++;
    end
  end

  // Called on a falling edge; returns on the falling edge after the handshake
  task automatic send_flit(input logic [31:0] d, input logic l);
    int w = 0;
    prog_TDATA  = d;
    prog_TLAST  = l;
    prog_TVALID = 1'b1;
    while (!prog_TREADY && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!prog_TREADY) chk("flit_accept_timeout", 32'(prog_TREADY), 32'h1);
    @(negedge clk);
    prog_TVALID = 1'b0;
    prog_TLAST  = 1'b0;
    prog_TDATA  = '0;
  endtask

  task automatic get_status(input string nm, input logic [31:0] exp, input int stall);
    int w = 0;
    while (!stat_TVALID && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_stat_vld"}, 32'(stat_TVALID), 32'h1);
    chk({nm, "_stat_dat"}, stat_TDATA, exp);
    chk({nm, "_stat_last"}, 32'(stat_TLAST), 32'h1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk($sformatf("%s_hold_vld%0d", nm, i), 32'(stat_TVALID), 32'h1);
      chk($sformatf("%s_hold_dat%0d", nm, i), stat_TDATA, exp);
    end
    stat_TREADY = 1'b1;
    @(negedge clk);
    stat_TREADY = 1'b0;
    chk({nm, "_busy_after"}, 32'(busy), 32'h0);
    chk({nm, "_stat_drop"}, 32'(stat_TVALID), 32'h0);
  endtask

  task automatic chk_cmds(input string nm, input int n, input logic [5:0][31:0] exp);
    logic [31:0] a;
    chk({nm, "_ncmd"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      a = (k < got.size()) ? got[k] : 32'hxxxxxxxx;
      chk($sformatf("%s_cmd%0d", nm, k), a, exp[k]);
    end
    chk({nm, "_idle_zero"}, 32'(idle_nz), 32'h0);
  endtask

  initial begin
    logic [5:0][31:0] t6_cmd;
    int w;

    vt[0].flit = {32'h12345678, 32'hDEADBEEF, 32'h00000010}; vt[0].nflit = 3; vt[0].ack = 0;
    vt[0].ncmd = 6; vt[0].stat = 32'h00000002;
    vt[0].cmd  = {32'h00040000, 32'h00035678, 32'h00021234, 32'h0003BEEF, 32'h0002DEAD, 32'h00010010};
    vt[1] = vt[0]; vt[1].ack = 1; vt[1].ncmd = 3; vt[1].stat = 32'h20000000;
    vt[2] = vt[0]; vt[2].ack = 2; vt[2].ncmd = 3; vt[2].stat = 32'h40000000;
    vt[3].flit = {32'h11112222, 32'hAAAA5555, 32'h000003FF}; vt[3].nflit = 3; vt[3].ack = 0;
    vt[3].ncmd = 3; vt[3].stat = 32'h60000001;
    vt[3].cmd  = {32'h0, 32'h0, 32'h0, 32'h00035555, 32'h0002AAAA, 32'h000103FF};
    vt[4].flit = {32'h0, 32'h0, 32'h00000005}; vt[4].nflit = 1; vt[4].ack = 0;
    vt[4].ncmd = 0; vt[4].stat = 32'h80000000; vt[4].cmd = '0;
    vt[5].flit = {32'h0, 32'h00000001, 32'h00000100}; vt[5].nflit = 2; vt[5].ack = 3;
    vt[5].ncmd = 4; vt[5].stat = 32'h00000001;
    vt[5].cmd  = {32'h0, 32'h0, 32'h00040000, 32'h00030001, 32'h00020000, 32'h00010100};

    // Outputs while held in reset
    repeat (2) @(negedge clk);
    chk("rst_prog_rdy", 32'(prog_TREADY), 32'h0);
    chk("rst_cmd_vld", 32'(cmd_TVALID), 32'h0);
    chk("rst_cmd_dat", cmd_TDATA, 32'h0);
    chk("rst_stat_vld", 32'(stat_TVALID), 32'h0);
    chk("rst_stat_dat", stat_TDATA, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(prog_TREADY), 32'h1);

    for (int i = 0; i < 6; i++) begin
      got.delete();
      idle_nz  = 0;
      ack_mode = vt[i].ack;
      for (int k = 0; k < vt[i].nflit; k++)
        send_flit(vt[i].flit[k], (k == vt[i].nflit - 1));
      get_status($sformatf("v%0d", i), vt[i].stat, 0);
      chk_cmds($sformatf("v%0d", i), vt[i].ncmd, vt[i].cmd);
    end

    // Reset while waiting for an ack, then a clean packet with a stalled status
    got.delete();
    idle_nz  = 0;
    ack_mode = 1;
    send_flit(32'h00000020, 1'b0);
    send_flit(32'hCAFEF00D, 1'b0);
    w = 0;
    while (got.size() < 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("t6_cmds_pre_rst", 32'(got.size()), 32'd3);
    repeat (5) @(negedge clk);
    chk("t6_busy_pre_rst", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("t6_rst_prog_rdy", 32'(prog_TREADY), 32'h0);
    chk("t6_rst_cmd_vld", 32'(cmd_TVALID), 32'h0);
    chk("t6_rst_cmd_dat", cmd_TDATA, 32'h0);
    chk("t6_rst_stat_vld", 32'(stat_TVALID), 32'h0);
    chk("t6_rst_stat_dat", stat_TDATA, 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rdy_after", 32'(prog_TREADY), 32'h1);
    chk("t6_no_stat_after", 32'(stat_TVALID), 32'h0);
    got.delete();
    idle_nz  = 0;
    ack_mode = 0;
    send_flit(32'h00000030, 1'b0);
    send_flit(32'h0BAD0001, 1'b1);
    get_status("t6", 32'h00000001, 5);
    t6_cmd = {32'h0, 32'h0, 32'h00040000, 32'h00030001, 32'h00020BAD, 32'h00010030};
    chk_cmds("t6", 4, t6_cmd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_cpu_loader.md
Name: axis_cpu_loader

Overview:
Programming master for axis_cpu. It accepts a program packet on an AXI-Stream input and serialises it into command words on the CPU's non-backpressured command input. It checks the CPU's command-output acknowledges and returns one status flit per packet. It sits between the host/DMA stream and one axis_cpu instance.

Parameters:
CODE_ADDR_WIDTH, 10, width of CPU instruction address
CPU_ID_WIDTH, 12, width of target id field in command words
TARGET_ID, 0, id of the CPU this loader programs
ACK_TIMEOUT, 63, cycles to wait for each acknowledge before error

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
prog_TDATA  in  32  first flit: start address (low CODE_ADDR_WIDTH bits); later flits: instructions
prog_TVALID  in  1  program stream valid
prog_TREADY  out  1  program stream ready
prog_TLAST  in  1  marks final instruction
cmd_TDATA  out  32  command word to CPU cmd_in
cmd_TVALID  out  1  single-cycle command strobe (no ready)
resp_TDATA  in  32  CPU cmd_out word
resp_TVALID  in  1  CPU cmd_out strobe
stat_TDATA  out  32  per-packet status
stat_TVALID  out  1  status valid
stat_TREADY  in  1  status ready
stat_TLAST  out  1  always 1 with stat_TVALID
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Command word: [31:20] id (CPU_ID_WIDTH, zero-extended), [19:16] op, [15:0] data. Ops: ADDR=1, WR_HI=2, WR_LO=3 (commit; CPU post-increments address), RUN=4, ACK=8 (CPU to loader, data = committed address).
- Reset (rst low, asynchronous): FSM=IDLE; prog_TREADY, cmd_TVALID, stat_TVALID, busy = 0; cmd_TDATA, stat_TDATA = 0; counters cleared. Reset mid-packet abandons the packet; no status is emitted.
- FSM states and transitions:
  - IDLE: prog_TREADY=1. An address flit loads addr and clears cnt.
    - If it carries TLAST: go to STAT with err=EMPTY.
    - Otherwise: go to ADDR.
  - ADDR: one cycle; drive ADDR op; go to FETCH.
  - FETCH: prog_TREADY=1. A flit latches the instruction and the last flag.
    - If addr+cnt > 2^CODE_ADDR_WIDTH-1: err=OVERFLOW, go to DRAIN (or STAT if that flit had TLAST).
    - Otherwise: go to HI.
  - HI: drive WR_HI with instr[31:16].
  - LO: drive WR_LO with instr[15:0]; load timer=ACK_TIMEOUT; go to WAIT_ACK.
  - WAIT_ACK: prog_TREADY=0.
    - Resp with id==TARGET_ID, op==ACK and data==addr+cnt (zero-extended): cnt++; go to RUN if last, else FETCH.
    - Matching id/op with wrong data: err=MISMATCH.
    - Timer reaching 0: err=TIMEOUT.
    - On either error: go to DRAIN if not last, else STAT.
  - RUN: drive RUN op, data 0, for one cycle; go to STAT.
  - DRAIN: prog_TREADY=1; discard flits up to and including TLAST; go to STAT.
  - STAT: stat_TVALID=1 and stat_TDATA = {err[2:0], 13'b0, cnt[15:0]}; hold until stat_TREADY; go to IDLE.
- Error codes: OK=0, TIMEOUT=1, MISMATCH=2, OVERFLOW=3, EMPTY=4. RUN is issued only when err=OK.
- Command outputs are registered. cmd_TVALID is high for exactly one cycle per command; cmd_TDATA is 0 when cmd_TVALID=0.
- Resp words with a different id or op, or arriving outside WAIT_ACK, are ignored.
- A resp word and a timer expiry in the same cycle: the resp wins.
- Per-instruction command latency: flit accept → WR_HI next cycle → WR_LO the cycle after.
- The address compare is done at CODE_ADDR_WIDTH+1 bits so wrap-around is detected, never silently wrapped.

Decomposition:
- Shared package axis_cpu_defs: op codes, field offsets/widths, error codes, status field layout (also used by axis_cpu).
- One natural sub-module: axis_cpu_cmd_fmt. Purely combinational; packs id/op/data into the 32-bit command word.

Test Plan:
1. Packet {0x010, 0xDEADBEEF, 0x12345678(LAST)}, CPU acks 0x010 then 0x011.
   - cmd sequence: 0x00010010, 0x0002DEAD, 0x0003BEEF, 0x00021234, 0x00035678, 0x00040000.
   - Status 0x00000002.
2. Same packet, no ack ever returned → after 63 idle cycles the second flit is drained; no RUN; status 0x20000000.
3. Ack for the first instruction carries data 0x011 → MISMATCH; remaining flit drained; status 0x40000000.
4. Start address 0x3FF with two instructions → first written and acked; second flagged OVERFLOW; status 0x60000001; no RUN.
5. Single flit 0x005 with LAST → no cmd_TVALID at all; status 0x80000000.
6. Mid-WAIT_ACK, assert rst low for 1 cycle → all outputs 0 asynchronously; next packet loads cleanly; stat_TREADY held low 5 cycles → stat_TVALID and stat_TDATA held stable.
